// File: rtl/arm_pkg.sv
// arm_pkg: shared widths, reset vector and fetch-entry type for the
// front end of the 5-stage ARM pipeline (fetch_stage and its FIFO).
package arm_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_INSTR_W   = 32;
    localparam int DEF_BUF_DEPTH = 2;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // One prefetched word as it travels to the IF/ID register.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc_plus4;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [DEF_ADDR_W-1:0] pc_inc(
        input logic [DEF_ADDR_W-1:0] pc
    );
        return pc + DEF_ADDR_W'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response signals plus the
// IF/ID register outputs of the fetch stage.
// master = fetch stage side (issues requests, drives IF/ID).
// slave  = memory / decode side (returns words, observes IF/ID).
interface fetch_stage_if
    import arm_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    logic               id_valid;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        output id_valid,
        output id_pc,
        output id_instr
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        input  id_valid,
        input  id_pc,
        input  id_instr
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding prefetched words.
// Ports: clk, rst (sync, active high), clear (flush, wins over push),
// push/push_data, pop, head (oldest entry), count, empty, full.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Pointer wrap handles depths that are not a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // A push into a full FIFO is ignored; upstream slot accounting
    // keeps that from happening.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage ARM pipeline. Owns the PC, issues
// in-order requests to instruction memory, buffers returned words in a
// prefetch FIFO and drives the IF/ID register.
// Ports: clk, rst (sync, active high); freeze holds IF/ID; branch_taken /
// branch_addr flush and redirect; bus (master) carries imem_req/addr,
// imem_rvalid/rdata and the IF/ID outputs id_valid, id_pc, id_instr.
module fetch_stage
    import arm_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    fetch_stage_if.master     bus
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int LW = CW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      drop_cnt;

    logic               id_valid;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;

    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    entry_t             head;
    entry_t             push_data;

    logic               rvalid;
    logic               push;
    logic               pop;
    logic               issue;
    logic [LW-1:0]      live;

    assign rvalid = bus.imem_rvalid;

    always_comb begin
        pop = !branch_taken && !freeze && !fifo_empty;

        // Slots held by live words: buffered plus in flight, minus
        // stale responses we will throw away. A word leaving for ID
        // this cycle frees its slot now, which keeps one word per
        // cycle flowing with a two-entry buffer.
        live = {1'b0, fifo_count}
             + {1'b0, outstanding}
             - {1'b0, drop_cnt}
             - LW'(pop);

        issue = !rst
             && !branch_taken
             && (live < LW'(BUF_DEPTH))
             && (!fifo_full || pop);

        push = rvalid && (drop_cnt == '0) && !branch_taken;

        push_data.pc_plus4 = resp_pc + ADDR_W'(4);
        push_data.instr    = bus.imem_rdata;
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.id_valid  = id_valid;
    assign bus.id_pc     = id_pc;
    assign bus.id_instr  = id_instr;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (branch_taken),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= ADDR_W'(RESET_PC);
            resp_pc     <= ADDR_W'(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_instr    <= '0;
        end else if (branch_taken) begin
            pc          <= branch_addr;
            resp_pc     <= branch_addr;
            outstanding <= outstanding - CW'(rvalid);
            // Every request still in flight belongs to the old path.
            drop_cnt    <= outstanding - CW'(rvalid);
            id_valid    <= 1'b0;
        end else begin
            if (issue) begin
                pc <= pc + ADDR_W'(4);
            end
            outstanding <= outstanding + CW'(issue) - CW'(rvalid);
            if (rvalid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end else begin
                    resp_pc <= resp_pc + ADDR_W'(4);
                end
            end
            if (!freeze) begin
                id_valid <= !fifo_empty;
                if (!fifo_empty) begin
                    id_pc    <= head.pc_plus4;
                    id_instr <= head.instr;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: drives fetch_stage with a fixed-latency memory model
// and checks the IF/ID stream against an in-order fetch-stream model.
module tb_fetch_stage;
    import arm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    int          cyc;
    int          lat;
    logic [31:0] key;
    logic        req_seen;
    logic [31:0] req_addr;
    int          passed;
    int          total;

    // One clock cycle: present the memory response due now, record the
    // request the DUT makes, then step past the rising edge.
    task automatic tick();
        mreq_t r;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        if (rst) begin
            memq.delete();
        end else if (memq.size() > 0 && memq[0].due == cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memq[0].addr ^ key;
            memq.delete(0);
        end
        #1;
        req_seen = bus.imem_req;
        req_addr = bus.imem_addr;
        if (req_seen === 1'b1) begin
            r.addr = bus.imem_addr;
            r.due  = cyc + lat;
            memq.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        tick();
        tick();
        total++;
        if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 ||
            bus.id_instr !== 32'h0) begin
            $display("FAIL reset_id got v=%b pc=%h i=%h want 0/0/0",
                     bus.id_valid, bus.id_pc, bus.id_instr);
        end else passed++;
        total++;
        if (req_seen !== 1'b0 || bus.imem_addr !== 32'h0) begin
            $display("FAIL reset_req got req=%b addr=%h want 0/0",
                     req_seen, bus.imem_addr);
        end else passed++;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        lat = 1;
        key = 32'h0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (req_seen !== 1'b1 || req_addr !== 32'(4 * k)) begin
                $display("FAIL stream_req k=%0d got %b/%h want 1/%h",
                         k, req_seen, req_addr, 32'(4 * k));
            end else passed++;
            total++;
            if (k < 2) begin
                if (bus.id_valid !== 1'b0) begin
                    $display("FAIL stream_early k=%0d got v=%b want 0",
                             k, bus.id_valid);
                end else passed++;
            end else begin
                if (bus.id_valid !== 1'b1 ||
                    bus.id_pc !== 32'(4 * (k - 1)) ||
                    bus.id_instr !== 32'(4 * (k - 2))) begin
                    $display("FAIL stream_id k=%0d got %b/%h/%h want 1/%h/%h",
                             k, bus.id_valid, bus.id_pc, bus.id_instr,
                             32'(4 * (k - 1)), 32'(4 * (k - 2)));
                end else passed++;
            end
        end
    endtask

    task automatic test_freeze();
        logic [31:0] want;
        lat = 1;
        key = $urandom();
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        total++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8) begin
            $display("FAIL freeze_setup got %b/%h want 1/00000008",
                     bus.id_valid, bus.id_pc);
        end else passed++;
        freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (req_seen !== 1'b0 || bus.id_valid !== 1'b1 ||
                bus.id_pc !== 32'h8 || bus.id_instr !== (32'h4 ^ key)) begin
                $display("FAIL freeze_hold k=%0d got req=%b %b/%h/%h want 0 1/8/%h",
                         k, req_seen, bus.id_valid, bus.id_pc,
                         bus.id_instr, 32'h4 ^ key);
            end else passed++;
        end
        freeze = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            want = 32'(12 + 4 * k);
            if (k == 0) begin
                total++;
                if (req_seen !== 1'b1 || req_addr !== 32'h10) begin
                    $display("FAIL freeze_resume_req got %b/%h want 1/00000010",
                             req_seen, req_addr);
                end else passed++;
            end
            total++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== want ||
                bus.id_instr !== ((want - 32'h4) ^ key)) begin
                $display("FAIL freeze_release k=%0d got %b/%h/%h want 1/%h/%h",
                         k, bus.id_valid, bus.id_pc, bus.id_instr,
                         want, (want - 32'h4) ^ key);
            end else passed++;
        end
    endtask

    task automatic test_branch_flush();
        int  n;
        bit  armed;
        logic [31:0] want;
        lat = 3;
        key = $urandom();
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        armed = 1'b0;
        for (int k = 0; k < 10 && !armed; k++) begin
            if (memq.size() == 2) armed = 1'b1;
            else tick();
        end
        total++;
        if (!armed) begin
            $display("FAIL branch_inflight got %0d want 2", memq.size());
        end else passed++;
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        tick();
        branch_taken = 1'b0;
        total++;
        if (req_seen !== 1'b0 || bus.id_valid !== 1'b0) begin
            $display("FAIL branch_cycle got req=%b v=%b want 0/0",
                     req_seen, bus.id_valid);
        end else passed++;
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            tick();
            if (k == 0) begin
                total++;
                if (req_seen !== 1'b1 || req_addr !== 32'h100) begin
                    $display("FAIL branch_first_req got %b/%h want 1/00000100",
                             req_seen, req_addr);
                end else passed++;
            end
            if (bus.id_valid === 1'b1) begin
                want = 32'h104 + 32'(4 * n);
                total++;
                if (bus.id_pc !== want ||
                    bus.id_instr !== ((want - 32'h4) ^ key)) begin
                    $display("FAIL branch_stream n=%0d got %h/%h want %h/%h",
                             n, bus.id_pc, bus.id_instr,
                             want, (want - 32'h4) ^ key);
                end else passed++;
                n++;
            end
        end
        total++;
        if (n < 3) begin
            $display("FAIL branch_timeout got %0d words want 3", n);
        end else passed++;
    endtask

    task automatic test_branch_freeze();
        int n;
        lat = 1;
        key = $urandom();
        do_reset();
        for (int k = 0; k < 6; k++) tick();
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        tick();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        total++;
        if (bus.id_valid !== 1'b0 || req_seen !== 1'b0) begin
            $display("FAIL bf_flush got v=%b req=%b want 0/0",
                     bus.id_valid, req_seen);
        end else passed++;
        tick();
        total++;
        if (req_seen !== 1'b1 || req_addr !== 32'h40) begin
            $display("FAIL bf_pc got %b/%h want 1/00000040",
                     req_seen, req_addr);
        end else passed++;
        n = 0;
        for (int k = 0; k < 10 && n == 0; k++) begin
            tick();
            if (bus.id_valid === 1'b1) n = 1;
        end
        total++;
        if (n == 0 || bus.id_pc !== 32'h44 ||
            bus.id_instr !== (32'h40 ^ key)) begin
            $display("FAIL bf_first got %b/%h/%h want 1/00000044/%h",
                     bus.id_valid, bus.id_pc, bus.id_instr, 32'h40 ^ key);
        end else passed++;
    endtask

    task automatic test_back_to_back_branch();
        int n;
        logic [31:0] want;
        lat = 2;
        key = $urandom();
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        tick();
        branch_addr  = 32'h300;
        tick();
        branch_taken = 1'b0;
        total++;
        if (bus.id_valid !== 1'b0) begin
            $display("FAIL b2b_flush got v=%b want 0", bus.id_valid);
        end else passed++;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 0) begin
                total++;
                if (req_seen !== 1'b1 || req_addr !== 32'h300) begin
                    $display("FAIL b2b_req got %b/%h want 1/00000300",
                             req_seen, req_addr);
                end else passed++;
            end
            if (bus.id_valid === 1'b1) begin
                want = 32'h304 + 32'(4 * n);
                total++;
                if (bus.id_pc !== want ||
                    bus.id_instr !== ((want - 32'h4) ^ key)) begin
                    $display("FAIL b2b_stream n=%0d got %h/%h want %h/%h",
                             n, bus.id_pc, bus.id_instr,
                             want, (want - 32'h4) ^ key);
                end else passed++;
                n++;
            end
        end
        total++;
        if (n < 4) begin
            $display("FAIL b2b_count got %0d want >=4", n);
        end else passed++;
    endtask

    task automatic test_wrap_reset();
        int n;
        logic [31:0] want;
        lat = 1;
        key = $urandom();
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        n = 0;
        for (int k = 0; k < 10 && n < 2; k++) begin
            tick();
            if (bus.id_valid === 1'b1) begin
                want = 32'(4 * n);
                total++;
                if (bus.id_pc !== want ||
                    bus.id_instr !== ((want - 32'h4) ^ key)) begin
                    $display("FAIL wrap n=%0d got %h/%h want %h/%h",
                             n, bus.id_pc, bus.id_instr,
                             want, (want - 32'h4) ^ key);
                end else passed++;
                n++;
            end
        end
        total++;
        if (n < 2) begin
            $display("FAIL wrap_timeout got %0d words want 2", n);
        end else passed++;
        rst = 1'b1;
        tick();
        total++;
        if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 ||
            bus.id_instr !== 32'h0 || req_seen !== 1'b0 ||
            bus.imem_addr !== 32'h0) begin
            $display("FAIL midreset got %b/%h/%h req=%b addr=%h want zeros",
                     bus.id_valid, bus.id_pc, bus.id_instr,
                     req_seen, bus.imem_addr);
        end else passed++;
        rst = 1'b0;
    endtask

    // Model: ID must show the fetch stream of the latest redirect target
    // in order, never a gap-skipped or stale word; freeze holds ID; a
    // redirect empties ID and restarts both streams at the target.
    task automatic test_random();
        logic [31:0] exp_addr;
        logic [31:0] exp_req;
        logic [31:0] ba;
        logic        fr;
        logic        br;
        logic        pv;
        logic [31:0] ppc;
        logic [31:0] pin;
        int          delivered;
        for (int run = 0; run < 3; run++) begin
            lat = 1 + run;
            key = $urandom();
            do_reset();
            exp_addr  = 32'h0;
            exp_req   = 32'h0;
            delivered = 0;
            for (int k = 0; k < 200; k++) begin
                fr = ($urandom_range(0, 9) < 3);
                br = ($urandom_range(0, 19) == 0);
                ba = $urandom() & 32'hFFFF_FFFC;
                pv  = bus.id_valid;
                ppc = bus.id_pc;
                pin = bus.id_instr;
                freeze       = fr;
                branch_taken = br;
                branch_addr  = ba;
                tick();
                total++;
                if (br) begin
                    if (req_seen !== 1'b0) begin
                        $display("FAIL rnd_req_br run=%0d k=%0d got %b want 0",
                                 run, k, req_seen);
                    end else passed++;
                    exp_req = ba;
                end else if (req_seen === 1'b1) begin
                    if (req_addr !== exp_req) begin
                        $display("FAIL rnd_req run=%0d k=%0d got %h want %h",
                                 run, k, req_addr, exp_req);
                    end else passed++;
                    exp_req = exp_req + 32'h4;
                end else passed++;
                total++;
                if (br) begin
                    if (bus.id_valid !== 1'b0) begin
                        $display("FAIL rnd_flush run=%0d k=%0d got %b want 0",
                                 run, k, bus.id_valid);
                    end else passed++;
                    exp_addr = ba;
                end else if (fr) begin
                    if (bus.id_valid !== pv || bus.id_pc !== ppc ||
                        bus.id_instr !== pin) begin
                        $display("FAIL rnd_hold run=%0d k=%0d got %b/%h/%h want %b/%h/%h",
                                 run, k, bus.id_valid, bus.id_pc,
                                 bus.id_instr, pv, ppc, pin);
                    end else passed++;
                end else if (bus.id_valid === 1'b1) begin
                    if (bus.id_pc !== exp_addr + 32'h4 ||
                        bus.id_instr !== (exp_addr ^ key)) begin
                        $display("FAIL rnd_id run=%0d k=%0d got %h/%h want %h/%h",
                                 run, k, bus.id_pc, bus.id_instr,
                                 exp_addr + 32'h4, exp_addr ^ key);
                    end else passed++;
                    exp_addr = exp_addr + 32'h4;
                    delivered++;
                end else passed++;
            end
            freeze       = 1'b0;
            branch_taken = 1'b0;
            total++;
            if (delivered < 20) begin
                $display("FAIL rnd_progress run=%0d got %0d want >=20",
                         run, delivered);
            end else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        lat    = 1;
        key    = '0;
        rst             = 1'b1;
        freeze          = 1'b0;
        branch_taken    = 1'b0;
        branch_addr     = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_freeze();
        test_branch_flush();
        test_branch_freeze();
        test_back_to_back_branch();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
